// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: MALU op codes,
// FSM state encoding and iteration count.
package mdu_seq_pkg;

   localparam int unsigned MDU_ITER = 32;

   localparam logic [3:0] MALU_MUL    = 4'b1000;
   localparam logic [3:0] MALU_MULH   = 4'b1001;
   localparam logic [3:0] MALU_MULHSU = 4'b1010;
   localparam logic [3:0] MALU_MULHU  = 4'b1011;
   localparam logic [3:0] MALU_DIV    = 4'b1100;
   localparam logic [3:0] MALU_DIVU   = 4'b1101;
   localparam logic [3:0] MALU_REM    = 4'b1110;
   localparam logic [3:0] MALU_REMU   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } mdu_state_e;

   // Any code without bit 3 set is not an MALU op and runs as MUL.
   function automatic logic [3:0] malu_norm(input logic [3:0] op);
      return op[3] ? op : MALU_MUL;
   endfunction

endpackage

// File: rtl/mdu_seq_iter_step.sv
// One iteration of the shared datapath: radix-2 shift-add multiply step
// or restoring-divide step, chosen by is_div_i.
module mdu_iter_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opb_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic [XLEN-1:0] div_diff;
   logic            div_ge;

   always_comb begin
      // Multiply: {hi,lo} holds partial product with the multiplier in lo.
      mul_sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
      // Divide: {hi,lo} holds partial remainder with the dividend in lo.
      div_shift = {hi_i, lo_i[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, opb_i});
      div_diff  = XLEN'(div_shift - {1'b0, opb_i});

      if (is_div_i) begin
         hi_o = div_ge ? div_diff : div_shift[XLEN-1:0];
         lo_o = {lo_i[XLEN-2:0], div_ge};
      end else begin
         hi_o = mul_sum[XLEN:1];
         lo_o = {mul_sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide unit with busy stall and done pulse.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiplies.
module mdu_seq
   import mdu_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ITER = MDU_ITER
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned CW = $clog2(ITER + 1);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e      state_q;
   logic [CW-1:0]   cnt_q;
   logic [3:0]      op_q;
   logic [XLEN-1:0] hi_q, lo_q, opb_q;
   logic            neg_q, neg_rem_q;
   logic            busy_q, done_q;
   logic [XLEN-1:0] result_q;

   logic [3:0]      op_n;
   logic            div_n, a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            sp_hit;
   logic [XLEN-1:0] sp_res;
   logic [XLEN-1:0] step_hi, step_lo;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0] quo_s, rem_s;
   logic [XLEN-1:0] res_d;

   mdu_iter_step #(.XLEN(XLEN)) u_step (
      .is_div_i (op_q[2]),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .opb_i    (opb_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   always_comb begin
      op_n  = malu_norm(op_i);
      div_n = op_n[2];
      // Signed-A ops: MULH, MULHSU, DIV, REM. Signed-B ops: MULH, DIV, REM.
      a_sgn = (op_n == MALU_MULH) || (op_n == MALU_MULHSU) ||
              (op_n == MALU_DIV)  || (op_n == MALU_REM);
      b_sgn = (op_n == MALU_MULH) || (op_n == MALU_DIV) || (op_n == MALU_REM);
      a_neg = a_sgn & rs1_i[XLEN-1];
      b_neg = b_sgn & rs2_i[XLEN-1];
      a_mag = a_neg ? -rs1_i : rs1_i;
      b_mag = b_neg ? -rs2_i : rs2_i;

      sp_hit = 1'b0;
      sp_res = '0;
      if (div_n && (rs2_i == '0)) begin
         sp_hit = 1'b1;
         sp_res = op_n[1] ? rs1_i : '1;
      end else if (div_n && !op_n[0] && (rs1_i == INT_MIN) && (rs2_i == '1)) begin
         sp_hit = 1'b1;
         sp_res = op_n[1] ? '0 : INT_MIN;
      end

      prod   = {step_hi, step_lo};
      prod_s = neg_q ? -prod : prod;
      quo_s  = neg_q ? -step_lo : step_lo;
      rem_s  = neg_rem_q ? -step_hi : step_hi;
      if (op_q[2])
         res_d = op_q[1] ? rem_s : quo_s;
      else
         res_d = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
   end

`ifdef MDU_FAST_MUL_EN
   logic signed [XLEN:0]   fa, fb;
   logic signed [2*XLEN-1:0] fprod;
   logic [XLEN-1:0]        fast_res;

   always_comb begin
      fa       = {a_neg, rs1_i};
      fb       = {b_neg, rs2_i};
      fprod    = (2*XLEN)'(fa * fb);
      fast_res = (op_n[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         opb_q     <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i) begin
                     op_q      <= op_n;
                     neg_q     <= a_neg ^ b_neg;
                     neg_rem_q <= a_neg;
                     hi_q      <= '0;
                     lo_q      <= div_n ? a_mag : b_mag;
                     opb_q     <= div_n ? b_mag : a_mag;
                     busy_q    <= 1'b1;
                     if (sp_hit) begin
                        state_q  <= ST_DONE;
                        result_q <= sp_res;
                        done_q   <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                     end else if (!div_n) begin
                        state_q  <= ST_DONE;
                        result_q <= fast_res;
                        done_q   <= 1'b1;
`endif
                     end else begin
                        state_q <= ST_CALC;
                        cnt_q   <= CW'(ITER);
                     end
                  end
               end
               ST_CALC: begin
                  hi_q  <= step_hi;
                  lo_q  <= step_lo;
                  cnt_q <= cnt_q - CW'(1);
                  // Final step's result is fixed up and registered on the same edge.
                  if (cnt_q == CW'(1)) begin
                     state_q  <= ST_DONE;
                     result_q <= res_d;
                     done_q   <= 1'b1;
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq.
module tb_mdu_seq;
   import mdu_seq_pkg::*;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [3:0]  op_i = '0;
   logic [31:0] rs1_i = '0;
   logic [31:0] rs2_i = '0;
   logic        flush_i = 1'b0;
   logic        busy_o, done_o;
   logic [31:0] result_o;

   int n_vec = 0;
   int n_err = 0;

   mdu_seq #(.XLEN(32), .ITER(32)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .op_i     (op_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .flush_i  (flush_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk_i = ~clk_i;

   // Caller sits 1 time unit after a rising edge; start is sampled at the next edge.
   task automatic issue_wait(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int lat, output logic [31:0] res, output logic busy_ok);
      int cyc;
      start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cyc = 1;
      busy_ok = 1'b1;
      while (!done_o && cyc < 50) begin
         busy_ok &= busy_o;
         @(posedge clk_i); #1;
         cyc++;
      end
      busy_ok &= busy_o;
      lat = cyc;
      res = result_o;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic busy_ok);
      @(posedge clk_i); #1;
      issue_wait(op, a, b, lat, res, busy_ok);
   endtask

   task automatic test_reset;
      #2;
      n_vec++;
      if ({busy_o, done_o, result_o} !== 34'h0) begin
         $display("FAIL reset_state: got busy=%b done=%b result=%h expected 0/0/0",
                  busy_o, done_o, result_o);
         n_err++;
      end
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_i = 1'b0;
   endtask

   task automatic test_mul;
      vec_t v[6] = '{
         '{MALU_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT},
         '{MALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT},
         '{MALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT},
         '{MALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT},
         '{MALU_MUL,    32'd7,        32'd3,         32'd21,        MUL_LAT},
         '{4'b0010,     32'd6,        32'd5,         32'd30,        MUL_LAT}
      };
      int lat; logic [31:0] res; logic bok;
      for (int i = 0; i < 6; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, lat, res, bok);
         n_vec++;
         if (res !== v[i].exp) begin
            $display("FAIL mul_result[%0d]: got %h expected %h", i, res, v[i].exp);
            n_err++;
         end
         n_vec++;
         if (lat !== v[i].lat || bok !== 1'b1) begin
            $display("FAIL mul_timing[%0d]: got lat=%0d busy=%b expected lat=%0d busy=1",
                     i, lat, bok, v[i].lat);
            n_err++;
         end
         @(posedge clk_i); #1;
         n_vec++;
         if ({busy_o, done_o} !== 2'b00) begin
            $display("FAIL mul_after_done[%0d]: got busy=%b done=%b expected 0/0", i, busy_o, done_o);
            n_err++;
         end
      end
   endtask

   task automatic test_div;
      vec_t v[10] = '{
         '{MALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33},
         '{MALU_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33},
         '{MALU_DIVU, 32'd100,       32'd7,         32'd14,        33},
         '{MALU_REMU, 32'd100,       32'd7,         32'd2,         33},
         '{MALU_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
         '{MALU_REMU, 32'd5,         32'd0,         32'd5,         1},
         '{MALU_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1},
         '{MALU_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1},
         '{MALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
         '{MALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1}
      };
      int lat; logic [31:0] res; logic bok;
      for (int i = 0; i < 10; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, lat, res, bok);
         n_vec++;
         if (res !== v[i].exp) begin
            $display("FAIL div_result[%0d]: got %h expected %h", i, res, v[i].exp);
            n_err++;
         end
         n_vec++;
         if (lat !== v[i].lat || bok !== 1'b1) begin
            $display("FAIL div_timing[%0d]: got lat=%0d busy=%b expected lat=%0d busy=1",
                     i, lat, bok, v[i].lat);
            n_err++;
         end
      end
   endtask

   task automatic test_flush;
      int cyc, lat; logic seen; logic [31:0] res; logic bok;
      @(posedge clk_i); #1;
      start_i = 1'b1; op_i = MALU_DIVU; rs1_i = 32'd100; rs2_i = 32'd7;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cyc = 1; seen = 1'b0;
      while (cyc < 10) begin
         seen |= done_o;
         @(posedge clk_i); #1;
         cyc++;
      end
      seen |= done_o;
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      n_vec++;
      if ({seen, busy_o, done_o} !== 3'b000) begin
         $display("FAIL flush_abort: got seen_done=%b busy=%b done=%b expected 0/0/0",
                  seen, busy_o, done_o);
         n_err++;
      end
      issue_wait(MALU_REMU, 32'd100, 32'd7, lat, res, bok);
      n_vec++;
      if (res !== 32'd2 || lat !== 33) begin
         $display("FAIL flush_restart: got res=%h lat=%0d expected 00000002 lat=33", res, lat);
         n_err++;
      end
   endtask

   task automatic test_start_ignored;
      int cyc;
      @(posedge clk_i); #1;
      start_i = 1'b1; op_i = MALU_DIVU; rs1_i = 32'd100; rs2_i = 32'd7;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cyc = 1;
      while (!done_o && cyc < 50) begin
         if (cyc == 5) begin
            start_i = 1'b1; op_i = MALU_MUL; rs1_i = 32'd9; rs2_i = 32'd9;
         end else begin
            start_i = 1'b0;
         end
         @(posedge clk_i); #1;
         cyc++;
      end
      start_i = 1'b0;
      n_vec++;
      if (result_o !== 32'd14 || cyc !== 33) begin
         $display("FAIL start_in_calc: got res=%h lat=%0d expected 0000000e lat=33", result_o, cyc);
         n_err++;
      end
   endtask

   task automatic test_async_reset;
      int cyc; logic seen;
      @(posedge clk_i); #1;
      start_i = 1'b1; op_i = MALU_DIVU; rs1_i = 32'd100; rs2_i = 32'd7;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (4) begin @(posedge clk_i); #1; end
      #2 rst_i = 1'b1;
      #1;
      n_vec++;
      if ({busy_o, done_o, result_o} !== 34'h0) begin
         $display("FAIL async_reset: got busy=%b done=%b result=%h expected 0/0/0",
                  busy_o, done_o, result_o);
         n_err++;
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      seen = 1'b0;
      for (cyc = 0; cyc < 40; cyc++) begin
         seen |= done_o | busy_o;
         @(posedge clk_i); #1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         $display("FAIL reset_no_done: got activity=%b expected 0", seen);
         n_err++;
      end
   endtask

   initial begin
      test_reset;
      test_mul;
      test_div;
      test_flush;
      test_start_ignored;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
